// File: rtl/cpu_pkg.sv
// Purpose: shared CPU definitions for the long-latency multiply unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents:
//   mul_state_t - multiplier sequencer states
//   ALUOP_MUL   - ALUOP encoding that selects the multiply unit
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } mul_state_t;

  localparam logic [2:0] ALUOP_MUL = 3'b100;

endpackage

// File: rtl/abs_neg_w.sv
// Purpose: conditional two's-complement negate of a WIDTH-bit value.
// Latency: combinational.
// Backpressure: none.
// Ports:
//   neg  - 1 = output the negation of din, 0 = pass din through
//   din  - input value
//   dout - din or -din, modulo 2^WIDTH
module abs_neg_w #(
  parameter int WIDTH = 8
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  assign dout = neg ? (~din + WIDTH'(1)) : din;

endmodule

// File: rtl/seq_mul_unit.sv
// Purpose: multi-cycle shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned per op.
// Latency: WIDTH+2 cycles from accepted START to DONE; one result per WIDTH+1 cycles back-to-back.
// Backpressure: START is ignored while RUN; a START in the FIN cycle is accepted (no queueing).
// Ports:
//   CLK, RESET      - clock, synchronous active-high reset
//   START, SIGNED   - request and signedness, sampled together with DATA1/DATA2
//   DATA1, DATA2    - multiplicand, multiplier
//   BUSY            - operation in progress (RUN or FIN)
//   DONE            - one-cycle pulse, RESULT/ZERO valid in that cycle
//   RESULT, ZERO    - full product and its zero flag, held until the next result
module seq_mul_unit
  import cpu_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               START,
  input  logic               SIGNED,
  input  logic [WIDTH-1:0]   DATA1,
  input  logic [WIDTH-1:0]   DATA2,
  output logic               BUSY,
  output logic               DONE,
  output logic [2*WIDTH-1:0] RESULT,
  output logic               ZERO
);

  mul_state_t         state;
  mul_state_t         state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   mag1;
  logic [WIDTH-1:0]   mag2;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_fixed;
  logic [2*WIDTH-1:0] result_q;
  logic               neg_q;
  logic               done_q;
  logic               zero_q;
  logic               accept;

  // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1), which
  // still fits the unsigned WIDTH-bit magnitude registers.
  abs_neg_w #(.WIDTH(WIDTH)) u_mag1 (
    .neg  (SIGNED & DATA1[WIDTH-1]),
    .din  (DATA1),
    .dout (mag1)
  );

  abs_neg_w #(.WIDTH(WIDTH)) u_mag2 (
    .neg  (SIGNED & DATA2[WIDTH-1]),
    .din  (DATA2),
    .dout (mag2)
  );

  // Sign correction of the unsigned product {acc_hi, mplier}.
  abs_neg_w #(.WIDTH(2*WIDTH)) u_fix (
    .neg  (neg_q),
    .din  ({acc_hi, mplier}),
    .dout (prod_fixed)
  );

  // FIN doubles as an accept slot so results can be issued back-to-back.
  assign accept = START && ((state == IDLE) || (state == FIN));

  // Partial-product add into the upper half, carry kept in bit WIDTH.
  assign sum = {1'b0, acc_hi} + ({(WIDTH+1){mplier[0]}} & {1'b0, mcand});

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (START) state_nxt = RUN;
      end
      RUN: begin
        if (cnt == CNT_W'(1)) state_nxt = FIN;
      end
      FIN: begin
        state_nxt = START ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc_hi   <= '0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      done_q <= (state == FIN);
      if (state == FIN) begin
        result_q <= prod_fixed;
        zero_q   <= (prod_fixed == '0);
      end
      // In FIN the product above is read before this overwrites the pair.
      if (accept) begin
        mcand  <= mag1;
        mplier <= mag2;
        acc_hi <= '0;
        cnt    <= CNT_W'(WIDTH);
        neg_q  <= SIGNED & (DATA1[WIDTH-1] ^ DATA2[WIDTH-1]);
      end else if (state == RUN) begin
        // Shift {sum, mplier} right by one: the low bit of sum becomes the
        // next settled product bit at the top of the multiplier register.
        acc_hi <= sum[WIDTH:1];
        mplier <= {sum[0], mplier[WIDTH-1:1]};
        cnt    <= cnt - CNT_W'(1);
      end
    end
  end

  assign BUSY   = (state != IDLE);
  assign DONE   = done_q;
  assign RESULT = result_q;
  assign ZERO   = zero_q;

endmodule

// File: tb/tb_seq_mul_unit.sv
module tb_seq_mul_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, sgn;
  logic [7:0]  d1, d2;
  logic        busy, done, zero;
  logic [15:0] res;

  logic        start16, sgn16;
  logic [15:0] a16, b16;
  logic        busy16, done16, zero16;
  logic [31:0] res16;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [15:0] res;
    int          cyc;
  } exp8_t;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp16_t;

  exp8_t  q8[$];
  exp16_t q16[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_mul_unit #(.WIDTH(8)) dut8 (
    .CLK(clk), .RESET(rst), .START(start), .SIGNED(sgn),
    .DATA1(d1), .DATA2(d2), .BUSY(busy), .DONE(done),
    .RESULT(res), .ZERO(zero)
  );

  seq_mul_unit #(.WIDTH(16)) dut16 (
    .CLK(clk), .RESET(rst), .START(start16), .SIGNED(sgn16),
    .DATA1(a16), .DATA2(b16), .BUSY(busy16), .DONE(done16),
    .RESULT(res16), .ZERO(zero16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitors: pop and compare whenever a DONE pulse is presented.
  always @(negedge clk) begin : mon8
    exp8_t e;
    if (done === 1'b1) begin
      if (q8.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done8 actual RESULT=%0h with no outstanding op (cycle %0d)", res, cyc);
      end else begin
        e = q8.pop_front();
        chk("result8", {16'h0, res}, {16'h0, e.res});
        chk("zero8", {31'h0, zero}, {31'h0, (e.res == 16'h0)});
        chk("latency8", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin : mon16
    exp16_t e;
    if (done16 === 1'b1) begin
      if (q16.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done16 actual RESULT=%0h with no outstanding op (cycle %0d)", res16, cyc);
      end else begin
        e = q16.pop_front();
        chk("result16", res16, e.res);
        chk("zero16", {31'h0, zero16}, {31'h0, (e.res == 32'h0)});
        chk("latency16", cyc, e.cyc);
      end
    end
  end

  // Drive one START cycle; operands are scrambled afterwards to show
  // post-acceptance changes have no effect.
  task automatic issue8(input logic s, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input bit push);
    @(negedge clk);
    sgn   = s;
    d1    = a;
    d2    = b;
    start = 1'b1;
    if (push) q8.push_back('{exp, cyc + 10});
    @(negedge clk);
    start = 1'b0;
    d1    = 8'($urandom);
    d2    = 8'($urandom);
    sgn   = 1'($urandom);
  endtask

  task automatic issue16(input logic s, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp);
    @(negedge clk);
    sgn16   = s;
    a16     = a;
    b16     = b;
    start16 = 1'b1;
    q16.push_back('{exp, cyc + 18});
    @(negedge clk);
    start16 = 1'b0;
    a16     = 16'($urandom);
    b16     = 16'($urandom);
  endtask

  task automatic wait_idle8(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!busy && q8.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk(name, {31'h0, ok}, 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_idle16(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!busy16 && q16.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk(name, {31'h0, ok}, 32'd1);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    rst = 1'b1; start = 1'b0; sgn = 1'b0; d1 = '0; d2 = '0;
    start16 = 1'b0; sgn16 = 1'b0; a16 = '0; b16 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_done", {31'h0, done}, 32'd0);
    chk("rst_result", {16'h0, res}, 32'd0);
    chk("rst_zero", {31'h0, zero}, 32'd1);
    chk("rst_result16", res16, 32'd0);
    chk("rst_zero16", {31'h0, zero16}, 32'd1);

    // 13*11 with BUSY duration
    issue8(1'b0, 8'd13, 8'd11, 16'h008F, 1'b1);
    n = 0;
    while (busy && n < 30) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", n, 32'd9);
    wait_idle8("idle_timeout_13x11");

    // Directed unsigned / signed vectors
    issue8(1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b1); wait_idle8("idle_timeout_ff_ff");
    issue8(1'b1, 8'hFD, 8'h05, 16'hFFF1, 1'b1); wait_idle8("idle_timeout_m3x5");
    issue8(1'b1, 8'h80, 8'h80, 16'h4000, 1'b1); wait_idle8("idle_timeout_min_min");
    issue8(1'b1, 8'h7F, 8'h80, 16'hC080, 1'b1); wait_idle8("idle_timeout_max_min");
    issue8(1'b1, 8'hFF, 8'hFF, 16'h0001, 1'b1); wait_idle8("idle_timeout_m1_m1");
    issue8(1'b1, 8'hFF, 8'h01, 16'hFFFF, 1'b1); wait_idle8("idle_timeout_m1_1");
    issue8(1'b0, 8'h80, 8'h80, 16'h4000, 1'b1); wait_idle8("idle_timeout_u80_80");
    issue8(1'b0, 8'd0, 8'd200, 16'h0000, 1'b1); wait_idle8("idle_timeout_0x200");

    // START held high with fresh operands every cycle: only j=0, 9, 18 accepted
    for (int j = 0; j < 19; j++) begin
      @(negedge clk);
      sgn   = 1'b0;
      start = 1'b1;
      d1    = 8'(j + 2);
      d2    = 8'(j + 3);
      if (j == 0)  q8.push_back('{16'h0006, cyc + 10});
      if (j == 9)  q8.push_back('{16'h0084, cyc + 10});
      if (j == 18) q8.push_back('{16'h01A4, cyc + 10});
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle8("idle_timeout_stream");

    // Reset during RUN cycle 4: aborted, no DONE
    issue8(1'b0, 8'd9, 8'd9, 16'h0000, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'h0, busy}, 32'd0);
    chk("abort_done", {31'h0, done}, 32'd0);
    chk("abort_result", {16'h0, res}, 32'd0);
    chk("abort_zero", {31'h0, zero}, 32'd1);
    repeat (15) @(negedge clk);
    issue8(1'b0, 8'd7, 8'd6, 16'h002A, 1'b1);
    wait_idle8("idle_timeout_7x6");

    // 16-bit build
    issue16(1'b1, 16'h8000, 16'h7FFF, 32'hC0008000); wait_idle16("idle_timeout16_a");
    issue16(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001); wait_idle16("idle_timeout16_b");
    issue16(1'b1, 16'hFFFF, 16'h8000, 32'h00008000); wait_idle16("idle_timeout16_c");

    chk("q8_drained", q8.size(), 32'd0);
    chk("q16_drained", q16.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
